part_1_init_xchg: RTL and testbench

//  Initiator-side vector exchange controller for the split co-simulation link; mirror of the target partition interface.
//  On each rising edge of a mission clock it snapshots that clock's outbound vector and freezes the clock.
//  It then sends the vector to the transport bridge and waits for the target's vector for the same event index.
//  On a matching reply it releases the freeze. The transport bridge (DPI/TCP) attaches to the put/get handshakes.

---
 rtl/part_1_init_xchg.sv | 152 +++++++++++++++
 tb/tb_part_1_init_xchg.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/part_1_init_xchg.sv
// Initiator-side vector exchange controller: snapshots each mission clock's outbound vector on its rising edge,
// freezes that clock, trades the vector with the target over put/get handshakes and releases the freeze on a matching reply.
module part_1_init_xchg #(
  parameter int NUM_CLK  = 4,
  parameter int W        = 9,
  parameter int WDOG_MAX = 10000
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_CLK-1:0]   clk_h,
  input  logic [NUM_CLK*W-1:0] tx_vec_i,
  output logic [NUM_CLK-1:0]   freeze_clk,
  output logic                 put_valid,
  input  logic                 put_ready,
  output logic [2:0]           put_idx,
  output logic [W-1:0]         put_data,
  input  logic                 get_valid,
  input  logic [2:0]           get_idx,
  input  logic [W-1:0]         get_data,
  output logic [NUM_CLK*W-1:0] rx_vec_o,
  output logic [NUM_CLK-1:0]   rx_vld_o,
  output logic                 busy_o,
  output logic [2:0]           err_o
);

  localparam int SW = $clog2(NUM_CLK);
  localparam int DW = $clog2(WDOG_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_HALT} state_t;
  state_t r_state, w_state_next;

  logic [NUM_CLK-1:0]   r_clk_h_d, r_pending, r_rx_vld;
  logic [NUM_CLK-1:0]   w_ev, w_set, w_clr;
  logic [W-1:0]         r_tx_buf [NUM_CLK];
  logic [NUM_CLK*W-1:0] r_rx_vec;
  logic [SW-1:0]        r_sel, w_low;
  logic [DW-1:0]        r_wdog;
  logic                 r_put_valid;
  logic [2:0]           r_put_idx;
  logic [W-1:0]         r_put_data;
  logic [2:0]           r_err;
  logic                 w_any, w_hs, w_idx_ok, w_match, w_mismatch, w_timeout;

  assign w_ev       = clk_h & ~r_clk_h_d;
  assign w_any      = |r_pending;
  assign w_hs       = r_put_valid & put_ready;
  // Upper index bits must be in range, otherwise an alias of sel would be accepted.
  assign w_idx_ok   = (int'(get_idx) < NUM_CLK) && (get_idx[SW-1:0] == r_sel);
  assign w_match    = (r_state == S_WAIT) && get_valid && w_idx_ok;
  assign w_mismatch = (r_state == S_WAIT) && get_valid && !w_idx_ok;
  assign w_timeout  = (r_state == S_WAIT) && !w_match && (r_wdog == DW'(WDOG_MAX));

  generate
    for (genvar gi = 0; gi < NUM_CLK; gi++) begin : g_slice
      assign w_set[gi] = w_ev[gi] & ~r_pending[gi];
      assign w_clr[gi] = w_match & (r_sel == SW'(gi));
    end
  endgenerate

  always_comb begin
    w_low = '0;
    for (int i = NUM_CLK - 1; i >= 0; i--) begin
      if (r_pending[i]) w_low = SW'(i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_any) w_state_next = S_SEND;
      S_SEND: if (w_hs) w_state_next = S_WAIT;
      S_WAIT: begin
        if (w_match)        w_state_next = S_IDLE;
        else if (w_timeout) w_state_next = S_HALT;
      end
      default: w_state_next = S_HALT;
    endcase
  end

  // Snapshot buffer: an event that overruns a pending slot leaves the stored vector untouched.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NUM_CLK; i++) begin
      if (w_set[i]) r_tx_buf[i] <= tx_vec_i[i*W +: W];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_clk_h_d <= '0;
      r_pending <= '0;
      r_rx_vld  <= '0;
      r_rx_vec  <= '0;
    end else begin
      r_clk_h_d <= clk_h;
      r_pending <= (r_pending & ~w_clr) | w_set;
      r_rx_vld  <= w_clr;
      for (int i = 0; i < NUM_CLK; i++) begin
        if (w_clr[i]) r_rx_vec[i*W +: W] <= get_data;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_put_valid <= 1'b0;
      r_put_idx   <= '0;
      r_put_data  <= '0;
      r_sel       <= '0;
      r_wdog      <= '0;
      r_err       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_put_valid <= 1'b1;
            r_put_idx   <= 3'(w_low);
            r_put_data  <= r_tx_buf[w_low];
            r_sel       <= w_low;
          end
        end
        S_SEND: begin
          if (w_hs) begin
            r_put_valid <= 1'b0;
            r_wdog      <= '0;
          end
        end
        S_WAIT: begin
          if (r_wdog != DW'(WDOG_MAX)) r_wdog <= r_wdog + DW'(1);
        end
        default: r_put_valid <= 1'b0;
      endcase
      r_err[0] <= r_err[0] | (|(w_ev & r_pending));
      r_err[1] <= r_err[1] | w_mismatch;
      r_err[2] <= r_err[2] | w_timeout;
    end
  end

  assign freeze_clk = r_pending;
  assign put_valid  = r_put_valid;
  assign put_idx    = r_put_idx;
  assign put_data   = r_put_data;
  assign rx_vec_o   = r_rx_vec;
  assign rx_vld_o   = r_rx_vld;
  assign busy_o     = (r_state != S_IDLE);
  assign err_o      = r_err;

endmodule

// File: tb/tb_part_1_init_xchg.sv
// Directed bench for part_1_init_xchg: single, simultaneous, backpressured, mismatched, overrun and timed-out exchanges.
module tb_part_1_init_xchg;
  localparam int NC = 4;
  localparam int W  = 9;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [NC-1:0] clk_h;
  logic [NC*W-1:0] tx_vec_i;
  logic [NC-1:0] freeze_clk;
  logic          put_valid, put_ready;
  logic [2:0]    put_idx;
  logic [W-1:0]  put_data;
  logic          get_valid;
  logic [2:0]    get_idx;
  logic [W-1:0]  get_data;
  logic [NC*W-1:0] rx_vec_o;
  logic [NC-1:0] rx_vld_o;
  logic          busy_o;
  logic [2:0]    err_o;

  int n_cmp = 0;
  int n_bad = 0;
  int n_put = 0;

  part_1_init_xchg #(.NUM_CLK(NC), .W(W), .WDOG_MAX(20)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clk_h(clk_h), .tx_vec_i(tx_vec_i),
    .freeze_clk(freeze_clk), .put_valid(put_valid), .put_ready(put_ready),
    .put_idx(put_idx), .put_data(put_data), .get_valid(get_valid),
    .get_idx(get_idx), .get_data(get_data), .rx_vec_o(rx_vec_o),
    .rx_vld_o(rx_vld_o), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    if (!rst_i && put_valid && put_ready) begin
      n_put++;
      $display("put  idx=%0d data=%03h", put_idx, put_data);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) @(negedge clk_i);
  endtask

  task automatic set_tx(input int e, input logic [W-1:0] v);
    tx_vec_i[e*W +: W] = v;
  endtask

  task automatic reply(input logic [2:0] idx, input logic [W-1:0] d);
    get_valid = 1'b1; get_idx = idx; get_data = d;
    tick();
    get_valid = 1'b0; get_idx = '0; get_data = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_freeze"}, freeze_clk, 0);
    check({tag, "_pvalid"}, put_valid, 0);
    check({tag, "_pidx"}, put_idx, 0);
    check({tag, "_pdata"}, put_data, 0);
    check({tag, "_rxvec"}, rx_vec_o, 0);
    check({tag, "_rxvld"}, rx_vld_o, 0);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_err"}, err_o, 0);
  endtask

  initial begin
    int base, k;
    rst_i = 1'b1; clk_h = '0; tx_vec_i = '0; put_ready = 1'b0;
    get_valid = 1'b0; get_idx = '0; get_data = '0;
    tick(3);
    check_all_zero("reset");
    rst_i = 1'b0;
    tick();

    // 1: single event on clock 0
    put_ready = 1'b1;
    clk_h[0] = 1'b1; set_tx(0, 9'h1A5);
    tick();
    clk_h[0] = 1'b0; set_tx(0, 9'h000);
    check("t1_freeze_a", freeze_clk, 4'b0001);
    check("t1_idle_pv", put_valid, 0);
    tick();
    check("t1_pvalid", put_valid, 1);
    check("t1_pidx", put_idx, 0);
    check("t1_pdata", put_data, 9'h1A5);
    check("t1_freeze_b", freeze_clk, 4'b0001);
    tick();
    check("t1_wait_pv", put_valid, 0);
    check("t1_freeze_c", freeze_clk, 4'b0001);
    reply(3'd0, 9'h05A);
    check("t1_freeze_rel", freeze_clk, 4'b0000);
    check("t1_rx0", rx_vec_o[0*W +: W], 9'h05A);
    check("t1_rxvld", rx_vld_o, 4'b0001);
    check("t1_busy", busy_o, 0);
    tick();
    check("t1_rxvld_end", rx_vld_o, 4'b0000);

    // 2: simultaneous edges on clocks 2 and 0
    clk_h = 4'b0101; set_tx(0, 9'h011); set_tx(2, 9'h122);
    tick();
    clk_h = 4'b0000;
    check("t2_freeze_a", freeze_clk, 4'b0101);
    tick();
    check("t2_pidx_a", put_idx, 0);
    check("t2_pdata_a", put_data, 9'h011);
    tick();
    reply(3'd0, 9'h0AA);
    check("t2_freeze_b", freeze_clk, 4'b0100);
    check("t2_rxvld_a", rx_vld_o, 4'b0001);
    k = 0;
    while (!put_valid && k < 10) begin tick(); k++; end
    check("t2_put_seen", put_valid, 1);
    check("t2_pidx_b", put_idx, 2);
    check("t2_pdata_b", put_data, 9'h122);
    tick();
    reply(3'd2, 9'h0BB);
    check("t2_freeze_c", freeze_clk, 4'b0000);
    check("t2_rxvec", rx_vec_o, {9'h000, 9'h0BB, 9'h000, 9'h0AA});

    // 3: backpressure on clock 3
    put_ready = 1'b0;
    clk_h[3] = 1'b1; set_tx(3, 9'h1F0);
    tick();
    clk_h[3] = 1'b0; set_tx(3, 9'h000);
    tick();
    for (int c = 1; c <= 5; c++) begin
      check($sformatf("t3_pv_c%0d", c), put_valid, 1);
      check($sformatf("t3_pd_c%0d", c), put_data, 9'h1F0);
      tick();
    end
    put_ready = 1'b1;
    tick();
    check("t3_fired", put_valid, 0);
    check("t3_busy", busy_o, 1);
    reply(3'd3, 9'h033);
    check("t3_rx3", rx_vec_o[3*W +: W], 9'h033);
    check("t3_freeze", freeze_clk, 4'b0000);

    // 4: index mismatch while waiting for clock 1
    clk_h[1] = 1'b1; set_tx(1, 9'h0C1);
    tick();
    clk_h[1] = 1'b0;
    tick(2);
    reply(3'd5, 9'h155);
    check("t4_oor_err", err_o, 3'b010);
    check("t4_oor_frz", freeze_clk, 4'b0010);
    check("t4_oor_rx1", rx_vec_o[1*W +: W], 9'h000);
    reply(3'd3, 9'h1FF);
    check("t4_err", err_o, 3'b010);
    check("t4_rx3_kept", rx_vec_o[3*W +: W], 9'h033);
    check("t4_busy", busy_o, 1);
    reply(3'd1, 9'h111);
    check("t4_rx1", rx_vec_o[1*W +: W], 9'h111);
    check("t4_freeze", freeze_clk, 4'b0000);
    tick();
    reply(3'd0, 9'h1EE);
    check("t4_idle_rx0", rx_vec_o[0*W +: W], 9'h0AA);
    check("t4_idle_err", err_o, 3'b010);

    // 6: overrun on clock 1, exactly one put
    base = n_put;
    put_ready = 1'b0;
    clk_h[1] = 1'b1; set_tx(1, 9'h0D1);
    tick();
    clk_h[1] = 1'b0;
    tick();
    clk_h[1] = 1'b1; set_tx(1, 9'h0EE);
    tick();
    clk_h[1] = 1'b0;
    check("t6_err", err_o, 3'b011);
    check("t6_pdata", put_data, 9'h0D1);
    put_ready = 1'b1;
    tick();
    reply(3'd1, 9'h0DD);
    check("t6_freeze", freeze_clk, 4'b0000);
    tick(4);
    check("t6_idle", busy_o, 0);
    check("t6_puts", n_put - base, 1);

    // 5: timeout on clock 2, then reset
    clk_h[2] = 1'b1; set_tx(2, 9'h022);
    tick();
    clk_h[2] = 1'b0;
    tick(2);
    tick(18);
    check("t5_no_to_yet", err_o[2], 0);
    k = 0;
    while (!err_o[2] && k < 6) begin tick(); k++; end
    check("t5_timeout", err_o, 3'b111);
    check("t5_freeze", freeze_clk, 4'b0100);
    check("t5_pvalid", put_valid, 0);
    check("t5_busy", busy_o, 1);
    reply(3'd2, 9'h1AB);
    check("t5_halt_rx2", rx_vec_o[2*W +: W], 9'h0BB);
    check("t5_halt_frz", freeze_clk, 4'b0100);
    clk_h[0] = 1'b1;
    tick();
    clk_h[0] = 1'b0;
    tick(2);
    check("t5_halt_newev", freeze_clk, 4'b0101);
    check("t5_halt_nopv", put_valid, 0);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check_all_zero("t5_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
